// File: rtl/aoi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aoi_ctrl_pkg
// Shared definitions for the AOI gate self-test sequencer:
//   - state_e       : sweep FSM states
//   - NUM_VEC       : number of input combinations swept (a,b,c,d -> 16)
//   - LAST_VEC      : index of the final vector in a sweep
//   - aoi_expected  : golden {e,f,g} for a 4-bit input vector
// Vector bit mapping: bit0=a, bit1=b, bit2=c, bit3=d.
// -----------------------------------------------------------------------------
package aoi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int         NUM_VEC  = 16;
    localparam logic [3:0] LAST_VEC = 4'(NUM_VEC - 1);

    // Golden model of the gate: e=a&b, f=c&d, g=~(e|f), packed as {e,f,g}.
    function automatic logic [2:0] aoi_expected(input logic [3:0] vec);
        logic e_v;
        logic f_v;
        logic g_v;
        e_v = vec[0] & vec[1];
        f_v = vec[2] & vec[3];
        g_v = ~(e_v | f_v);
        return {e_v, f_v, g_v};
    endfunction

endpackage

// File: rtl/aoi_dwell_timer.sv
// -----------------------------------------------------------------------------
// aoi_dwell_timer
// Settle-time counter for the sweep sequencer. Counts enabled cycles from zero
// and flags the terminal count when DWELL cycles have elapsed (count DWELL-1).
// The count may step one past the terminal value on the cycle the parent
// leaves the settle phase, so the width covers 0..DWELL.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   clr  in   synchronous clear to zero (has priority over en)
//   en   in   count enable
//   tc   out  terminal count reached (count == DWELL-1)
// -----------------------------------------------------------------------------
module aoi_dwell_timer #(
    parameter int  DWELL = 2,
    localparam int CNT_W = $clog2(DWELL + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/aoi_sweep_controller.sv
// -----------------------------------------------------------------------------
// aoi_sweep_controller
// Self-test sequencer for an external four-input AOI gate. On start it walks
// all 16 input vectors (a fastest), holds each for DWELL settle cycles plus
// one check cycle, samples {e,f,g} on the check edge and compares against the
// golden function. Reports pass, number of failing vectors, and the index and
// observed outputs of the first failing vector.
//
// Parameters:
//   DWELL           settle cycles per vector, 1..255
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   start           in   begin a sweep (ignored while busy or with abort)
//   abort           in   cancel a running sweep, results discarded
//   a, b, c, d      out  gate inputs (vector bit0..bit3)
//   e, f, g         in   gate outputs under test
//   busy            out  sweep in progress
//   done            out  sweep complete, held until next start or reset
//   pass            out  done with zero mismatches
//   err_count       out  number of mismatching vectors, 0..16
//   first_fail      out  index of first mismatching vector, 0 if none
//   first_fail_obs  out  observed {e,f,g} at first_fail, 0 if none
// All outputs come straight from flops; e/f/g and start only reach them
// through the next-state logic.
// -----------------------------------------------------------------------------
module aoi_sweep_controller
    import aoi_ctrl_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail,
    output logic [2:0] first_fail_obs
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] vec_q;
    logic [3:0] vec_d;
    logic [4:0] err_q;
    logic [4:0] err_d;
    logic [3:0] ff_q;
    logic [3:0] ff_d;
    logic [2:0] ffo_q;
    logic [2:0] ffo_d;
    logic [3:0] drive_q;
    logic [3:0] drive_d;
    logic       busy_q;
    logic       busy_d;
    logic       done_q;
    logic       done_d;
    logic       pass_q;
    logic       pass_d;

    logic       dwell_tc_s;
    logic       dwell_clr_s;
    logic       dwell_en_s;
    logic [2:0] obs_s;
    logic       mismatch_s;
    logic       go_s;

    // Settle counter only runs in SETTLE; it sits at zero everywhere else so
    // every entry into SETTLE begins a fresh dwell.
    assign dwell_en_s  = (state_q == SETTLE);
    assign dwell_clr_s = (state_q != SETTLE);

    aoi_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk (clk),
        .rst (rst),
        .clr (dwell_clr_s),
        .en  (dwell_en_s),
        .tc  (dwell_tc_s)
    );

    assign obs_s      = {e, f, g};
    assign mismatch_s = (obs_s != aoi_expected(vec_q));
    // abort outranks start, so both together never launch a sweep.
    assign go_s       = start & ~abort;

    // Next-state and result-update logic.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffo_d   = ffo_q;

        case (state_q)
            IDLE: begin
                if (go_s) begin
                    state_d = SETTLE;
                    vec_d   = 4'd0;
                    err_d   = 5'd0;
                    ff_d    = 4'd0;
                    ffo_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = 4'd0;
                    err_d   = 5'd0;
                    ff_d    = 4'd0;
                    ffo_d   = 3'd0;
                end else if (dwell_tc_s) begin
                    state_d = CHECK;
                end else begin
                    state_d = SETTLE;
                end
            end

            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = 4'd0;
                    err_d   = 5'd0;
                    ff_d    = 4'd0;
                    ffo_d   = 3'd0;
                end else begin
                    if (mismatch_s) begin
                        err_d = err_q + 5'd1;
                        // A zero count before this vector means it is the
                        // first failure of the sweep.
                        if (err_q == 5'd0) begin
                            ff_d  = vec_q;
                            ffo_d = obs_s;
                        end else begin
                            ff_d  = ff_q;
                            ffo_d = ffo_q;
                        end
                    end else begin
                        err_d = err_q;
                    end

                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        vec_d   = vec_q + 4'd1;
                    end
                end
            end

            DONE: begin
                if (go_s) begin
                    state_d = SETTLE;
                    vec_d   = 4'd0;
                    err_d   = 5'd0;
                    ff_d    = 4'd0;
                    ffo_d   = 3'd0;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
                vec_d   = 4'd0;
                err_d   = 5'd0;
                ff_d    = 4'd0;
                ffo_d   = 3'd0;
            end
        endcase
    end

    // Output values are derived from the next state so that the registered
    // outputs line up with the state they describe.
    always_comb begin
        drive_d = 4'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;

        case (state_d)
            SETTLE, CHECK: begin
                drive_d = vec_d;
                busy_d  = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
                pass_d = (err_d == 5'd0);
            end
            IDLE: begin
                drive_d = 4'd0;
            end
            default: begin
                drive_d = 4'd0;
            end
        endcase
    end

    // State, result and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 4'd0;
            err_q   <= 5'd0;
            ff_q    <= 4'd0;
            ffo_q   <= 3'd0;
            drive_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffo_q   <= ffo_d;
            drive_q <= drive_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign a              = drive_q[0];
    assign b              = drive_q[1];
    assign c              = drive_q[2];
    assign d              = drive_q[3];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail     = ff_q;
    assign first_fail_obs = ffo_q;

endmodule

// File: tb/tb_aoi_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_aoi_sweep_controller
// Bench for aoi_sweep_controller with DWELL=2. A behavioural AOI gate with
// selectable faults sits on a..d / e..g. When a sweep is launched, the bench
// walks its own gate model over all 16 vectors and queues the expected
// results; they are popped and compared when done rises. Per-cycle checks
// cover busy/done timing and the stepping of a..d.
// Fault modes: 0 correct, 1 g stuck-at-0, 2 e stuck-at-1,
//              3 g inverted on vectors 10 and 13 only.
// -----------------------------------------------------------------------------
module tb_aoi_sweep_controller;

    localparam int DW       = 2;
    localparam int VEC_CYC  = DW + 1;
    localparam int SWEEP_CY = 16 * VEC_CYC;

    typedef struct {
        int err;
        int ff;
        int ffo;
        int pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       a, b, c, d;
    logic       e, f, g;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_fail;
    logic [2:0] first_fail_obs;

    int   fault_mode = 0;
    int   checks     = 0;
    int   failures   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    aoi_sweep_controller #(.DWELL(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .a              (a),
        .b              (b),
        .c              (c),
        .d              (d),
        .e              (e),
        .f              (f),
        .g              (g),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail     (first_fail),
        .first_fail_obs (first_fail_obs)
    );

    // Gate under test, possibly faulty; returns {e,f,g}.
    function automatic logic [2:0] gate_fn(input logic [3:0] v, input int mode);
        logic ge, gf, gg;
        ge = v[0] & v[1];
        gf = v[2] & v[3];
        gg = ~(ge | gf);
        case (mode)
            1: gg = 1'b0;
            2: ge = 1'b1;
            3: if (v == 4'd10 || v == 4'd13) gg = ~gg;
            default: ;
        endcase
        return {ge, gf, gg};
    endfunction

    always_comb {e, f, g} = gate_fn({d, c, b, a}, fault_mode);

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected sweep results from the bench gate model versus the golden truth.
    task automatic push_expected(input int mode);
        exp_t x;
        logic [3:0] v;
        logic [2:0] gold, obs;
        x.err = 0; x.ff = 0; x.ffo = 0;
        for (int i = 0; i < 16; i++) begin
            v    = 4'(i);
            gold = {v[0] & v[1], v[2] & v[3], ~((v[0] & v[1]) | (v[2] & v[3]))};
            obs  = gate_fn(v, mode);
            if (obs != gold) begin
                if (x.err == 0) begin
                    x.ff  = i;
                    x.ffo = int'(obs);
                end
                x.err++;
            end
        end
        x.pass = (x.err == 0) ? 1 : 0;
        sb_q.push_back(x);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_pass"}, int'(pass), 0);
        check_eq({tag, "_abcd"}, int'({d, c, b, a}), 0);
        check_eq({tag, "_err"},  int'(err_count), 0);
        check_eq({tag, "_ff"},   int'(first_fail), 0);
        check_eq({tag, "_ffo"},  int'(first_fail_obs), 0);
    endtask

    // Launch a sweep and follow it for SWEEP_CY edges. restart_j/abort_j/rst_j
    // give the edge (relative to the start edge) at which that input is high;
    // -1 disables it.
    task automatic run_sweep(input int mode, input int restart_j,
                             input int abort_j, input int rst_j);
        exp_t x;
        bit   interrupted;
        interrupted = 1'b0;
        fault_mode  = mode;
        push_expected(mode);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j <= SWEEP_CY; j++) begin
            if (interrupted) begin
                check_idle("intr");
            end else if (j < SWEEP_CY) begin
                check_eq("busy_run", int'(busy), 1);
                check_eq("done_run", int'(done), 0);
                check_eq("abcd_step", int'({d, c, b, a}), j / VEC_CYC);
            end else begin
                check_eq("busy_end", int'(busy), 0);
                check_eq("done_end", int'(done), 1);
                check_eq("abcd_end", int'({d, c, b, a}), 0);
                if (sb_q.size() == 0) begin
                    check_eq("sb_empty", 0, 1);
                end else begin
                    x = sb_q.pop_front();
                    check_eq("err_count", int'(err_count), x.err);
                    check_eq("first_fail", int'(first_fail), x.ff);
                    check_eq("first_fail_obs", int'(first_fail_obs), x.ffo);
                    check_eq("pass", int'(pass), x.pass);
                end
            end
            start = (j + 1 == restart_j);
            abort = (j + 1 == abort_j);
            rst   = (j + 1 == rst_j);
            if (j + 1 == abort_j || j + 1 == rst_j) interrupted = 1'b1;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        if (interrupted) sb_q.delete();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Correct gate from IDLE.
        run_sweep(0, -1, -1, -1);

        // done holds; abort in DONE is ignored.
        tick();
        check_eq("done_hold", int'(done), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check_eq("done_after_abort", int'(done), 1);
        check_eq("pass_after_abort", int'(pass), 1);

        // Faulty gates, each launched from DONE (results must clear).
        run_sweep(1, -1, -1, -1);
        run_sweep(2, -1, -1, -1);
        run_sweep(3, -1, -1, -1);

        // Abort at edge 10 with a faulty gate, then a clean sweep with a
        // start re-pulse at edge 20 that must be ignored.
        run_sweep(2, -1, 10, -1);
        run_sweep(0, 20, -1, -1);

        // Reset mid-sweep at edge 30 with a faulty gate.
        run_sweep(1, -1, -1, 30);
        tick();
        check_idle("after_rst");

        // start together with abort must not launch a sweep.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        check_idle("start_abort");

        // Final clean sweep after all of the above.
        run_sweep(0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
